seven_segment_scan_driver: RTL and testbench

Time-multiplexed driver for a bank of common-segment seven-segment digits, generalising the single-digit hex encoder to DIGIT_COUNT digits. It holds a display word loaded through a valid/ready handshake and updates the visible word only at frame boundaries, so a frame never shows a mix of old and new digits. It scans one digit per refresh slot with dead-time to suppress ghosting and offers optional leading-zero blanking. It sits between the numeric datapath and the board's segment/anode pins.

---
 rtl/seven_segment_scan_driver.sv | 202 ++++++++++++++++++++
 tb/tb_seven_segment_scan_driver.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_segment_scan_driver
//
// Time-multiplexed driver for DIGIT_COUNT common-segment seven-segment digits.
// A display word is accepted through a valid/ready handshake into a pending
// register and copied to the visible display register only at a frame
// boundary, so a frame never mixes old and new digits. One digit is scanned
// per refresh slot; the first DEAD_CYCLES of every slot keep all digits off
// to suppress ghosting. Optional leading-zero blanking.
//
// Ports:
//   clock            : single clock, rising edge
//   resetN           : synchronous active-low reset
//   value            : hex nibbles, value[3:0] is digit 0 (rightmost)
//   pointEnable      : decimal point per digit, captured with value
//   valueValid       : producer offers value/pointEnable
//   valueReady       : pending register empty, transfer will be accepted
//   leadingZeroBlank : live mode bit, blank leading zero digits
//   segmentEnableN   : active-low segments (bit0 top ... bit6 center)
//   pointEnableN     : active-low decimal point of the scanned digit
//   digitEnableN     : active-low digit select, at most one bit low
// ---------------------------------------------------------------------------
module seven_segment_scan_driver #(
    parameter int unsigned DIGIT_COUNT     = 4,
    parameter int unsigned REFRESH_DIVIDER = 50000,
    parameter int unsigned DEAD_CYCLES     = 2
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic [4*DIGIT_COUNT-1:0] value,
    input  logic [DIGIT_COUNT-1:0]   pointEnable,
    input  logic                     valueValid,
    output logic                     valueReady,
    input  logic                     leadingZeroBlank,
    output logic [6:0]               segmentEnableN,
    output logic                     pointEnableN,
    output logic [DIGIT_COUNT-1:0]   digitEnableN
);

    localparam int unsigned VAL_W = 4 * DIGIT_COUNT;
    localparam int unsigned IDX_W = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;
    localparam int unsigned PRE_W = (REFRESH_DIVIDER > 1) ? $clog2(REFRESH_DIVIDER) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIVIDER - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGIT_COUNT - 1);

    // Active-high glyph for one hex nibble.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // State registers
    logic [PRE_W-1:0]       prescaler_q, prescaler_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic [VAL_W-1:0]       display_q, display_d;
    logic [DIGIT_COUNT-1:0] point_q, point_d;
    logic [VAL_W-1:0]       pending_q, pending_d;
    logic [DIGIT_COUNT-1:0] pending_point_q, pending_point_d;
    logic                   pending_full_q, pending_full_d;

    // Output registers
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic [DIGIT_COUNT-1:0] dig_q, dig_d;

    // Combinational helpers
    logic                   wrap_c;
    logic                   frame_end_c;
    logic                   accept_c;
    logic                   dead_c;
    logic [DIGIT_COUNT-1:0] blank_c;
    logic                   zero_run_c;
    logic [3:0]             cur_nib_c;
    logic                   cur_point_c;
    logic                   cur_blank_c;
    logic [DIGIT_COUNT-1:0] cur_sel_c;

    assign valueReady = ~pending_full_q;

    // Slot and frame timing.
    always_comb begin
        wrap_c      = (prescaler_q == PRE_LAST);
        frame_end_c = wrap_c && (index_q == IDX_LAST);
        accept_c    = valueValid && !pending_full_q;
        dead_c      = (32'(prescaler_q) < DEAD_CYCLES);
    end

    // Leading-zero run from the most significant digit; digit 0 never blanks.
    always_comb begin
        blank_c    = '0;
        zero_run_c = leadingZeroBlank;
        for (int d = int'(DIGIT_COUNT) - 1; d >= 1; d--) begin
            zero_run_c = zero_run_c && (display_q[4*d +: 4] == 4'h0);
            blank_c[d] = zero_run_c;
        end
    end

    // Select the data of the digit currently being scanned.
    always_comb begin
        cur_nib_c   = 4'h0;
        cur_point_c = 1'b0;
        cur_blank_c = 1'b0;
        cur_sel_c   = '0;
        for (int d = 0; d < int'(DIGIT_COUNT); d++) begin
            if (index_q == IDX_W'(d)) begin
                cur_nib_c    = display_q[4*d +: 4];
                cur_point_c  = point_q[d];
                cur_blank_c  = blank_c[d];
                cur_sel_c[d] = 1'b1;
            end
        end
    end

    // Next-state for scan counters, handshake and display word.
    always_comb begin
        prescaler_d     = prescaler_q;
        index_d         = index_q;
        display_d       = display_q;
        point_d         = point_q;
        pending_d       = pending_q;
        pending_point_d = pending_point_q;
        pending_full_d  = pending_full_q;

        if (wrap_c) begin
            prescaler_d = '0;
            index_d     = (index_q == IDX_LAST) ? '0 : index_q + IDX_W'(1);
        end else begin
            prescaler_d = prescaler_q + PRE_W'(1);
        end

        // Consume pending at the boundary; a same-cycle transfer cannot
        // collide because acceptance requires pending to be empty.
        if (frame_end_c && pending_full_q) begin
            display_d      = pending_q;
            point_d        = pending_point_q;
            pending_full_d = 1'b0;
        end

        if (accept_c) begin
            pending_d       = value;
            pending_point_d = pointEnable;
            pending_full_d  = 1'b1;
        end
    end

    // Output decode: one cycle behind the scan state.
    always_comb begin
        seg_d = cur_blank_c ? 7'h7F : ~hex_glyph(cur_nib_c);
        dp_d  = ~cur_point_c;
        dig_d = dead_c ? '1 : ~cur_sel_c;
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            prescaler_q     <= '0;
            index_q         <= '0;
            display_q       <= '0;
            point_q         <= '0;
            pending_q       <= '0;
            pending_point_q <= '0;
            pending_full_q  <= 1'b0;
            seg_q           <= 7'h7F;
            dp_q            <= 1'b1;
            dig_q           <= '1;
        end else begin
            prescaler_q     <= prescaler_d;
            index_q         <= index_d;
            display_q       <= display_d;
            point_q         <= point_d;
            pending_q       <= pending_d;
            pending_point_q <= pending_point_d;
            pending_full_q  <= pending_full_d;
            seg_q           <= seg_d;
            dp_q            <= dp_d;
            dig_q           <= dig_d;
        end
    end

    assign segmentEnableN = seg_q;
    assign pointEnableN   = dp_q;
    assign digitEnableN   = dig_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
module tb_seven_segment_scan_driver;

    localparam int DC  = 4;
    localparam int RD  = 8;
    localparam int DCY = 2;
    localparam int FRAME = DC * RD;

    logic        clock;
    logic        resetN;
    logic [15:0] value;
    logic [3:0]  pointEnable;
    logic        valueValid;
    logic        valueReady;
    logic        leadingZeroBlank;
    logic [6:0]  segmentEnableN;
    logic        pointEnableN;
    logic [3:0]  digitEnableN;

    seven_segment_scan_driver #(
        .DIGIT_COUNT(DC),
        .REFRESH_DIVIDER(RD),
        .DEAD_CYCLES(DCY)
    ) dut (
        .clock(clock),
        .resetN(resetN),
        .value(value),
        .pointEnable(pointEnable),
        .valueValid(valueValid),
        .valueReady(valueReady),
        .leadingZeroBlank(leadingZeroBlank),
        .segmentEnableN(segmentEnableN),
        .pointEnableN(pointEnableN),
        .digitEnableN(digitEnableN)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: time since reset plus display/pending words.
    int          m_t = 0;
    logic [15:0] m_disp = '0, m_pend = '0;
    logic [3:0]  m_pt = '0, m_pend_pt = '0;
    bit          m_full = 0;
    int          last_d, last_c;
    bit          last_acc;

    function automatic logic [6:0] ref_seg(input logic [15:0] w, input int d, input logic lzb);
        logic [6:0] g;
        logic [3:0] n;
        bit blank;
        n = w[4*d +: 4];
        blank = 0;
        if (lzb && d > 0) begin
            blank = 1;
            for (int k = 3; k >= d; k--)
                if (w[4*k +: 4] != 4'h0) blank = 0;
        end
        case (n)
            4'h0: g = 7'h3F; 4'h1: g = 7'h06; 4'h2: g = 7'h5B; 4'h3: g = 7'h4F;
            4'h4: g = 7'h66; 4'h5: g = 7'h6D; 4'h6: g = 7'h7D; 4'h7: g = 7'h07;
            4'h8: g = 7'h7F; 4'h9: g = 7'h6F; 4'hA: g = 7'h77; 4'hB: g = 7'h7C;
            4'hC: g = 7'h39; 4'hD: g = 7'h5E; 4'hE: g = 7'h79; default: g = 7'h71;
        endcase
        return blank ? 7'h7F : ~g;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, m_t);
        end
    endtask

    // One clock: predict outputs, advance model, compare.
    task automatic step();
        logic [6:0] es;
        logic       ed;
        logic [3:0] eg;
        bit         acc;
        int         d, c;
        d = -1;
        c = -1;
        if (!resetN) begin
            es = 7'h7F; ed = 1'b1; eg = 4'hF;
        end else begin
            d  = (m_t / RD) % DC;
            c  = m_t % RD;
            es = ref_seg(m_disp, d, leadingZeroBlank);
            ed = ~m_pt[d];
            eg = (c < DCY) ? 4'hF : ~(4'b0001 << d);
        end
        @(posedge clock);
        acc = 0;
        if (!resetN) begin
            m_t = 0; m_disp = '0; m_pt = '0; m_full = 0;
        end else begin
            acc = valueValid && !m_full;
            if ((m_t % FRAME) == FRAME - 1 && m_full) begin
                m_disp = m_pend; m_pt = m_pend_pt; m_full = 0;
            end
            if (acc) begin
                m_pend = value; m_pend_pt = pointEnable; m_full = 1;
            end
            m_t++;
        end
        last_d = d; last_c = c; last_acc = acc;
        #1;
        n_tests++;
        if (segmentEnableN !== es || pointEnableN !== ed || digitEnableN !== eg
            || valueReady !== !m_full) begin
            n_fail++;
            $display("FAIL scan t=%0d seg=%h/%h dp=%b/%b dig=%b/%b rdy=%b/%b (got/expected)",
                     m_t, segmentEnableN, es, pointEnableN, ed, digitEnableN, eg,
                     valueReady, !m_full);
        end
    endtask

    task automatic do_reset(input int n);
        resetN = 1'b0;
        repeat (n) step();
        resetN = 1'b1;
    endtask

    task automatic send(input logic [15:0] v, input logic [3:0] p);
        int n;
        valueValid = 1'b1; value = v; pointEnable = p;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_acc && n < 100);
        check("send_accepted", 32'(last_acc), 32'd1);
        valueValid = 1'b0;
    endtask

    task automatic run_to(input int t);
        int n;
        n = 0;
        while (m_t < t && n < 1000) begin
            step();
            n++;
        end
    endtask

    typedef struct {
        logic [15:0]     v;
        logic [3:0]      p;
        logic            lzb;
        logic [3:0][6:0] seg;
        logic [3:0]      dpn;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int n;
        resetN = 1'b0; valueValid = 1'b0; value = '0; pointEnable = '0;
        leadingZeroBlank = 1'b0;

        vecs[0] = '{16'h12AF, 4'b0100, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011};
        vecs[1] = '{16'h0050, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        vecs[3] = '{16'h0050, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111};
        vecs[4] = '{16'h0000, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
        vecs[5] = '{16'h0F00, 4'b1000, 1'b1, {7'h7F, 7'h0E, 7'h40, 7'h40}, 4'b0111};
        vecs[6] = '{16'h8000, 4'b0001, 1'b1, {7'h00, 7'h40, 7'h40, 7'h40}, 4'b1110};

        // Reset values and dead-time after release.
        resetN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_seg", 32'(segmentEnableN), 32'h7F);
            check("rst_dp", 32'(pointEnableN), 32'h1);
            check("rst_dig", 32'(digitEnableN), 32'hF);
            check("rst_ready", 32'(valueReady), 32'h1);
        end
        resetN = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check("rel_dig", 32'(digitEnableN), (i >= 3 && i <= 8) ? 32'hE : 32'hF);
        end

        // Table-driven load and blanking.
        foreach (vecs[i]) begin
            leadingZeroBlank = vecs[i].lzb;
            send(vecs[i].v, vecs[i].p);
            repeat (2 * FRAME) step();
            for (int k = 0; k < FRAME; k++) begin
                step();
                if (last_c == 4) begin
                    check("tbl_seg", 32'(segmentEnableN), 32'(vecs[i].seg[last_d]));
                    check("tbl_dp", 32'(pointEnableN), 32'(vecs[i].dpn[last_d]));
                end
            end
        end
        leadingZeroBlank = 1'b0;

        // Handshake hold-off and tear-free update.
        do_reset(2);
        run_to(10);
        valueValid = 1'b1; value = 16'h4321; pointEnable = 4'b0000;
        step();
        check("hs_accept_a", 32'(last_acc), 32'd1);
        value = 16'h8765;
        n = 0;
        while (valueReady !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("hs_ready_wait", 32'(n), 32'd21);
        step();
        check("hs_accept_b", 32'(last_acc), 32'd1);
        check("hs_ready_low", 32'(valueReady), 32'd0);
        valueValid = 1'b0;
        run_to(37);
        check("hs_frame_a", 32'(segmentEnableN), 32'h79);
        run_to(69);
        check("hs_frame_b", 32'(segmentEnableN), 32'h12);

        // Transfer in the boundary cycle waits for the next boundary.
        do_reset(2);
        run_to(31);
        valueValid = 1'b1; value = 16'h0009; pointEnable = 4'b0001;
        step();
        valueValid = 1'b0;
        check("bw_ready_low", 32'(valueReady), 32'd0);
        run_to(37);
        check("bw_still_old", 32'(segmentEnableN), 32'h40);
        check("bw_old_dp", 32'(pointEnableN), 32'd1);
        run_to(64);
        check("bw_ready_back", 32'(valueReady), 32'd1);
        run_to(69);
        check("bw_new", 32'(segmentEnableN), 32'h10);
        check("bw_new_dp", 32'(pointEnableN), 32'd0);

        // Reset mid-frame with pending data.
        send(16'h1111, 4'b0000);
        run_to(((m_t / FRAME) + 2) * FRAME + 1);
        send(16'h2222, 4'b0000);
        run_to((m_t / FRAME) * FRAME + 17);
        check("mr_pending", 32'(valueReady), 32'd0);
        resetN = 1'b0;
        step();
        check("mr_seg_off", 32'(segmentEnableN), 32'h7F);
        check("mr_dig_off", 32'(digitEnableN), 32'hF);
        step();
        check("mr_ready", 32'(valueReady), 32'd1);
        resetN = 1'b1;
        run_to(37);
        check("mr_zero0", 32'(segmentEnableN), 32'h40);
        run_to(69);
        check("mr_lost", 32'(segmentEnableN), 32'h40);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            valueValid  = ($urandom % 3) == 0;
            value       = 16'($urandom);
            pointEnable = 4'($urandom);
            if (($urandom % 50) == 0) leadingZeroBlank = ~leadingZeroBlank;
            resetN = (($urandom % 400) == 0) ? 1'b0 : 1'b1;
            step();
        end
        resetN = 1'b1;
        valueValid = 1'b0;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
